// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer. Accepts one pipeline request at a time,
// checks its address range and funct3, issues it to the data memory for a
// single cycle, captures load data one cycle later and holds the response
// until the pipeline takes it.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid & ready are both high. The side raising valid keeps its payload
// stable until that edge. rsp_valid is not withdrawn before rsp_ready.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [4:0]  mem_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LWAIT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Highest legal byte address, widened to match the 33-bit end-address sum.
    localparam logic [32:0] ADDR_MAX = (33'd1 << ADDR_BITS) - 33'd1;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic [1:0]  nbytes_m1;
    logic [32:0] last_byte;
    logic        range_err;
    logic        funct3_err;
    logic        req_err;

    // Request checks: last byte touched must stay in range (33 bits, no wrap),
    // and funct3 must be a legal size/sign for the access type.
    always_comb begin
        nbytes_m1 = 2'd3;
        case (req_funct3[1:0])
            2'd0:    nbytes_m1 = 2'd0;
            2'd1:    nbytes_m1 = 2'd1;
            default: nbytes_m1 = 2'd3;
        endcase
        last_byte = {1'b0, req_addr} + {31'b0, nbytes_m1};
        range_err = (last_byte > ADDR_MAX);
        if (req_we) begin
            funct3_err = (req_funct3 > 3'd2);
        end else begin
            funct3_err = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        end
        req_err = range_err || funct3_err;
    end

    // State and response registers; reset drops any pending load or response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next state, memory issue in the accept cycle, and the single LWAIT sample.
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_ctrl    = 5'd0;
        mem_addr    = 32'd0;
        mem_wr_data = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = RESP;
                    end else begin
                        mem_ctrl    = {req_funct3, req_we, 1'b1};
                        mem_addr    = req_addr;
                        mem_wr_data = req_wdata;
                        err_d       = 1'b0;
                        if (req_we) begin
                            rdata_d = 32'd0;
                            state_d = RESP;
                        end else begin
                            state_d = LWAIT;
                        end
                    end
                end
            end
            LWAIT: begin
                rdata_d = mem_rd_data;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a byte-array memory model answers the DUT's memory
// port, a reference model predicts each response from the access rules, and
// a monitor pops and compares responses whenever a handshake occurs.
module tb_lsu_mem_ctrl;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  mem_ctrl;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        busy;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_ctrl   (mem_ctrl),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  ref_mem[65536];
    logic [7:0]  dev_mem[65536];
    logic        hold_rsp = 1'b0;
    logic        mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory-side extension of a little-endian 4-byte window.
    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'd0:    return {{24{raw[7]}}, raw[7:0]};
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd4:    return {24'd0, raw[7:0]};
            3'd5:    return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Reference: is this request a fault?
    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        longint last;
        logic   bad_f3;
        last   = {32'd0, addr};
        last   = last + size_bytes(f3[1:0]) - 1;
        bad_f3 = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        return (last > 65535) || bad_f3;
    endfunction

    // Reference: apply the request to the model memory and give {err, rdata}.
    function automatic logic [32:0] ref_apply(input logic we, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] raw;
        int          a;
        if (ref_err(we, f3, addr)) return {1'b1, 32'd0};
        a = int'(addr[15:0]);
        if (we) begin
            for (int i = 0; i < size_bytes(f3[1:0]); i++) ref_mem[a + i] = wd[8*i +: 8];
            return {1'b0, 32'd0};
        end
        raw = 32'd0;
        for (int i = 0; i < size_bytes(f3[1:0]); i++) raw[8*i +: 8] = ref_mem[a + i];
        return {1'b0, ext_load(f3, raw)};
    endfunction

    // ---------------- memory model (device side) ----------------
    // Samples the issue port mid-cycle; load data appears in the next cycle,
    // otherwise the read bus carries random junk every cycle.
    initial begin : mem_model
        logic [31:0] pend;
        logic        pend_v;
        logic [15:0] a;
        mem_rd_data = 32'd0;
        for (int i = 0; i < 65536; i++) dev_mem[i] = 8'd0;
        forever begin
            @(negedge clk);
            pend_v = 1'b0;
            pend   = 32'd0;
            if (mem_ctrl[0] === 1'b1) begin
                a = mem_addr[15:0];
                if (mem_ctrl[1] === 1'b1) begin
                    for (int i = 0; i < size_bytes(mem_ctrl[3:2]); i++)
                        dev_mem[16'(a + 16'(i))] = mem_wr_data[8*i +: 8];
                end else begin
                    for (int i = 0; i < 4; i++) pend[8*i +: 8] = dev_mem[16'(a + 16'(i))];
                    pend   = ext_load(mem_ctrl[4:2], pend);
                    pend_v = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            mem_rd_data = pend_v ? pend : $urandom();
        end
    end

    // ---------------- response-ready driver ----------------
    initial begin : rdy_drv
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        prev_stall = 1'b0;
        logic        prev_rst   = 1'b1;
        logic [32:0] prev_rsp   = 33'd0;
        forever begin
            @(negedge clk);
            if (prev_stall && !prev_rst) begin
                check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                check("rsp_hold_data", 64'({rsp_err, rsp_rdata}), 64'(prev_rsp));
            end
            if (rsp_valid === 1'b1) check("req_ready_in_resp", 64'(req_ready), 64'd0);
            if (mon_en && !(req_valid === 1'b1 && req_ready === 1'b1))
                check("mem_port_quiet", {27'd0, mem_ctrl, mem_addr | mem_wr_data}, 64'd0);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got err=%b rdata=%h, expected no response", rsp_err, rsp_rdata);
                end else begin
                    check("rsp", 64'({rsp_err, rsp_rdata}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
            prev_rsp   = {rsp_err, rsp_rdata};
            prev_rst   = rst;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_junk();
        req_we     = 1'($urandom());
        req_funct3 = 3'($urandom());
        req_addr   = $urandom();
        req_wdata  = $urandom();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 50) check("req_ready_timeout", 64'(req_ready), 64'd1);
    endtask

    // Presents one request; called 1 time unit after a rising edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic hold);
        logic        e;
        logic [32:0] exp;
        int          k;
        wait_ready();
        e   = ref_err(we, f3, addr);
        exp = ref_apply(we, f3, addr, wd);
        exp_q.push_back(exp);
        if (hold) hold_rsp = 1'b1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        check("issue_ctrl", 64'(mem_ctrl), e ? 64'd0 : 64'({f3, we, 1'b1}));
        check("issue_addr", 64'(mem_addr), e ? 64'd0 : 64'(addr));
        check("issue_wdata", 64'(mem_wr_data), e ? 64'd0 : 64'(wd));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drive_junk();
        check("busy_after_accept", 64'(busy), 64'd1);
        if (!e && !we) begin
            check("load_not_early", 64'(rsp_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        check("rsp_latency", 64'(rsp_valid), 64'd1);
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                check("bp_rdata", 64'(rsp_rdata), 64'(exp[31:0]));
                check("bp_req_ready", 64'(req_ready), 64'd0);
                check("bp_valid", 64'(rsp_valid), 64'd1);
                @(posedge clk);
                #1;
            end
            hold_rsp = 1'b0;
        end
        k = 0;
        while (busy !== 1'b0 && k < 50) begin
            req_valid = 1'($urandom());
            drive_junk();
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = 1'b0;
        if (k >= 50) check("rsp_drain_timeout", 64'(busy), 64'd0);
    endtask

    // Load interrupted by reset while waiting for memory data.
    task automatic reset_mid_load(input logic [31:0] addr);
        wait_ready();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = addr;
        req_wdata  = 32'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rml_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rml_no_valid_in_rst", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rml_req_ready", 64'(req_ready), 64'd1);
        check("rml_busy_clear", 64'(busy), 64'd0);
        for (int c = 0; c < 3; c++) begin
            check("rml_no_valid", 64'(rsp_valid), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'd0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mem_ctrl", 64'(mem_ctrl), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        mon_en = 1'b1;

        // store / load pair
        do_req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 3'd2, 32'h100, 32'd0, 1'b0);
        // backpressure on a completed load
        do_req(1'b0, 3'd2, 32'h100, 32'd0, 1'b1);
        // range boundary
        do_req(1'b0, 3'd2, 32'hFFFC, 32'd0, 1'b0);
        do_req(1'b0, 3'd0, 32'hFFFF, 32'd0, 1'b0);
        do_req(1'b0, 3'd2, 32'hFFFD, 32'd0, 1'b0);
        do_req(1'b0, 3'd1, 32'hFFFF, 32'd0, 1'b0);
        do_req(1'b1, 3'd0, 32'h10000, 32'h55, 1'b0);
        do_req(1'b0, 3'd2, 32'hFFFFFFFF, 32'd0, 1'b0);
        // bad funct3
        do_req(1'b0, 3'd3, 32'h100, 32'd0, 1'b0);
        do_req(1'b1, 3'd4, 32'h100, 32'h12345678, 1'b0);
        // reset during a pending load, then the same load again
        reset_mid_load(32'h100);
        do_req(1'b0, 3'd2, 32'h100, 32'd0, 1'b0);

        // randomized mix
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom());
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       addr = 32'h100 + $urandom_range(0, 15);
                1:       addr = 32'hFFF8 + $urandom_range(0, 15);
                2:       addr = $urandom();
                default: addr = $urandom_range(0, 63);
            endcase
            do_req(we, f3, addr, $urandom(), ($urandom_range(0, 15) == 0));
        end

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
